lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller sitting directly upstream of the writeback mux.
- Takes MemRead/MemWrite, address and store data from the execute stage and runs a req/ack transaction to a variable-latency data memory.
- Produces the registered load word that drives the mux's write_data_out input (MemToReg=2'b10).
- Asserts stall to freeze the PC and architectural writes until the access finishes.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before the access is aborted (must be ≥2).
- ERR_DATA, 32'hDEADBEEF, value loaded into read_data on a timeout.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from decode/execute.
- MemWrite  in  1  store request.
- addr  in  ADDR_W  byte address (alu_out).
- store_data  in  DATA_W  rt value for stores.
- read_data  out  DATA_W  registered load result, feeds the writeback mux.
- load_valid  out  1  one-cycle pulse, read_data newly valid.
- stall  out  1  hold PC and suppress register-file write.
- bus_err  out  1  one-cycle pulse on timeout.
- misaligned  out  1  one-cycle pulse on misaligned access (see Optional Feature).
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, timeout counter=0, all outputs 0 (read_data=0, mem_addr=0, mem_wdata=0).
- FSM has three states: IDLE, WAIT, DONE.
- IDLE, request present (MemRead|MemWrite):
  - Capture addr, store_data and we=MemWrite into mem_addr, mem_wdata and mem_we.
  - Set mem_req=1 at the next edge and go to WAIT. Counter is cleared.
  - If MemRead and MemWrite are both high, the write wins.
- WAIT:
  - mem_req, mem_addr, mem_wdata and mem_we are held stable.
  - Counter increments each cycle without mem_ack.
  - On mem_ack: mem_req=0 at the next edge. For a read, read_data<=mem_rdata and load_valid=1 for one cycle. Go to DONE.
  - If counter reaches TIMEOUT_CYCLES-1 with no ack: mem_req=0, bus_err pulses, read_data<=ERR_DATA for reads, go to DONE.
- DONE: stall=0 for exactly one cycle so the instruction retires and the writeback mux samples read_data. The still-present MemRead/MemWrite is not re-issued. Go to IDLE.
- stall is combinational: (state==IDLE && (MemRead|MemWrite)) || state==WAIT.
- Load latency from request to retire: ack-cycle + 2 (minimum 3 cycles when ack arrives on the first WAIT cycle).
- read_data holds its value until the next load completes; stores do not change it.
- mem_ack in IDLE or DONE is ignored.
- rst asserted mid-transaction: mem_req drops at that edge, the transaction is abandoned, and a late mem_ack is ignored.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: in IDLE, a request with addr[1:0]≠0 issues no memory request. The FSM goes directly to DONE, misaligned pulses for one cycle, and read_data is unchanged.
- Undefined: misaligned is tied to 0 and mem_addr[1:0] is forced to 2'b00 (word access).

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - MemToReg encodings shared with the writeback mux: ALU=2'b00, PC=2'b01, MEM=2'b10.
  - ERR_DATA default.
- One natural sub-module: lsu_timeout_ctr (clear, enable, terminal-count output).

Test Plan:
- Load, addr=32'h0000_0010, ack after 2 WAIT cycles with rdata=32'h1234_5678 → stall high for 3 cycles, read_data=32'h1234_5678, load_valid pulses in DONE.
- Store, addr=32'h20, data=32'hCAFEF00D, ack on first WAIT cycle → mem_we=1, address and data stable while mem_req is high, read_data unchanged, no load_valid.
- Load with ack never asserted, TIMEOUT_CYCLES=16 → bus_err pulses after 16 WAIT cycles, read_data=32'hDEADBEEF.
- MemRead and MemWrite both high → write transaction issued; then rst pulsed during WAIT → mem_req=0 next cycle, state IDLE, a late ack causes no response.
- Back-to-back loads (MemRead held across DONE) → exactly one mem_req per instruction, with one IDLE cycle between transactions.
- With LSU_ALIGN_CHECK_EN defined, load addr=32'h13 → no mem_req, misaligned pulses, stall=0 after one cycle. Without the macro → mem_addr=32'h10.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl_pkg
// Shared definitions for the load/store controller and its neighbours.
//   lsu_state_e     : controller FSM encoding (IDLE / WAIT / DONE)
//   MEM_TO_REG_*    : writeback mux select encodings; the load path is MEM
//   LSU_ERR_DATA    : word returned to the pipeline when a load times out
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b01;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b10;

  localparam logic [31:0] LSU_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/lsu_mem_ctrl_timeout_ctr.sv
// -----------------------------------------------------------------------------
// lsu_timeout_ctr
// Small up-counter that bounds how long the controller waits for mem_ack.
// Ports:
//   clk_i     : system clock, rising edge
//   rst_i     : synchronous active-high reset
//   clear_i   : return the count to zero (has priority over enable_i)
//   enable_i  : advance the count by one
//   tc_o      : high while the count equals TERMINAL-1
// -----------------------------------------------------------------------------
module lsu_timeout_ctr #(
  parameter int unsigned TERMINAL = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(TERMINAL);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over enable so that every new access starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count is zero on the first WAIT cycle, so TERMINAL-1 marks the
  // TERMINAL-th cycle spent waiting.
  assign tc_o = (count_q == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store controller between the execute stage and a variable-latency data
// memory. Runs one req/ack transaction per load or store, stalls the pipeline
// while it is outstanding and presents a registered load word to the
// writeback mux (MemToReg = MEM_TO_REG_MEM).
//
// Configuration macro: LSU_ALIGN_CHECK_EN
//   defined   : accesses with addr[1:0] != 0 are rejected without touching
//               memory and pulse 'misaligned'
//   undefined : 'misaligned' is tied low and the low two address bits are
//               dropped (word access)
//
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   MemRead, MemWrite    : access request from execute (write wins if both)
//   addr, store_data     : byte address and store word
//   read_data            : registered load result
//   load_valid           : one-cycle pulse, read_data newly updated
//   stall                : freeze PC and register-file write
//   bus_err              : one-cycle pulse, access timed out
//   misaligned           : one-cycle pulse, access rejected for alignment
//   mem_req/we/addr/wdata: request to data memory, stable until completion
//   mem_rdata, mem_ack   : memory response
// -----------------------------------------------------------------------------
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(LSU_ERR_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] read_data,
  output logic              load_valid,
  output logic              stall,
  output logic              bus_err,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  lsu_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              load_valid_q, load_valid_d;
  logic              bus_err_q, bus_err_d;

  logic              req_present;
  logic              addr_misaligned;
  logic [ADDR_W-1:0] issue_addr;
  logic              timeout_tc;

  assign req_present = MemRead | MemWrite;

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  assign addr_misaligned = (addr[1:0] != 2'b00);
  assign issue_addr      = addr;
  assign misaligned      = misaligned_q;
`else
  // Word-only memory: the byte offset is simply discarded.
  assign addr_misaligned = 1'b0;
  assign issue_addr      = addr & ~ADDR_W'(3);
  assign misaligned      = 1'b0;
`endif

  // The counter only runs while waiting; any other state holds it at zero
  // so the next access always gets the full timeout window.
  lsu_timeout_ctr #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (state_q != WAIT),
    .enable_i ((state_q == WAIT) && !mem_ack),
    .tc_o     (timeout_tc)
  );

  // Next-state and datapath logic. Request fields are captured only on the
  // IDLE->WAIT transition so they stay stable for the whole handshake; the
  // status pulses default low and are raised for the single DONE cycle.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    read_data_d  = read_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misaligned_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_present) begin
          if (addr_misaligned) begin
            state_d = DONE;
`ifdef LSU_ALIGN_CHECK_EN
            misaligned_d = 1'b1;
`endif
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = issue_addr;
            mem_wdata_d = store_data;
            state_d     = WAIT;
          end
        end
      end

      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            read_data_d  = mem_rdata;
            load_valid_d = 1'b1;
          end
          state_d = DONE;
        end else if (timeout_tc) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!mem_we_q) begin
            read_data_d = ERR_DATA;
          end
          state_d = DONE;
        end
      end

      // Retire cycle: the request inputs are still those of the finished
      // instruction, so they are deliberately not looked at here.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      read_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      read_data_q  <= read_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
`ifdef LSU_ALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // Stall must rise in the same cycle the request appears, hence combinational.
  assign stall = ((state_q == IDLE) && req_present) || (state_q == WAIT);

  assign read_data  = read_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Scoreboard bench for lsu_mem_ctrl. The stimulus side works out, from the
// load/store rules alone, which memory request each instruction should make
// and what the pipeline should see when it retires, and queues both. A
// memory responder consumes the request queue and answers with a chosen
// latency; a retire monitor consumes the response queue.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] read_data;
  logic        load_valid;
  logic        stall;
  logic        bus_err;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  lsu_mem_ctrl #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TIMEOUT),
    .ERR_DATA       (ERR_WORD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .store_data (store_data),
    .read_data  (read_data),
    .load_valid (load_valid),
    .stall      (stall),
    .bus_err    (bus_err),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat > 0: ack on that WAIT cycle; 0: never ack; -1: abandoned by reset
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } reqT;

  typedef struct {
    logic        lv;
    logic        be;
    logic        mis;
    logic [31:0] rd;
    int          stallCycles;
  } respT;

  reqT  reqQ[$];
  respT respQ[$];

  logic [31:0] refMem  [logic [31:0]];
  logic [31:0] bankMem [logic [31:0]];
  logic [31:0] modelRd;

  int nTests = 0;
  int nFail  = 0;

  // Contents of a memory word nobody has written yet.
  function automatic logic [31:0] initWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one instruction, queue its expected memory request and retire
  // response, then return in its retire cycle with the inputs still held.
  task automatic applyStimulus(input logic isRd, input logic isWr, input logic [31:0] a,
                               input logic [31:0] d, input int lat);
    reqT         rq;
    respT        rs;
    logic [31:0] ea;
    logic        mis;
    int          k;
`ifdef LSU_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
    ea  = a;
`else
    mis = 1'b0;
    ea  = a & 32'hFFFF_FFFC;
`endif
    rs.lv  = 1'b0;
    rs.be  = 1'b0;
    rs.mis = mis;
    if (mis) begin
      rs.stallCycles = 1;
    end else begin
      rq.we    = isWr;
      rq.addr  = ea;
      rq.wdata = d;
      rq.lat   = lat;
      reqQ.push_back(rq);
      if (lat == 0) begin
        rs.be          = 1'b1;
        rs.stallCycles = 1 + TIMEOUT;
        if (!isWr) modelRd = ERR_WORD;
      end else begin
        rs.stallCycles = 1 + lat;
        if (isWr) begin
          refMem[ea] = d;
        end else begin
          modelRd = refMem.exists(ea) ? refMem[ea] : initWord(ea);
          rs.lv   = 1'b1;
        end
      end
    end
    rs.rd = modelRd;
    respQ.push_back(rs);

    MemRead    = isRd;
    MemWrite   = isWr;
    addr       = a;
    store_data = d;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (stall && k < 60);
    if (stall) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL retire_wait: stall still %b after %0d cycles, required 0", stall, k);
    end
  endtask

  task automatic idleCycles(input int n);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write+read together (write wins), then reset lands while waiting.
  task automatic resetMidTransaction();
    reqT rq;
    rq.we    = 1'b1;
    rq.addr  = 32'h44;
    rq.wdata = 32'h0BAD_F00D;
    rq.lat   = -1;
    reqQ.push_back(rq);
    MemRead    = 1'b1;
    MemWrite   = 1'b1;
    addr       = 32'h44;
    store_data = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    checkOutput("stall_in_wait", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelRd = 32'h0;
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_read_data", read_data, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("late_ack_load_valid", {31'b0, load_valid}, 32'd0);
      checkOutput("late_ack_mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("late_ack_read_data", read_data, 32'd0);
    end
  endtask

  // Memory responder: checks each request against the queue, holds it to
  // be stable, acks at the chosen latency and sends a stray ack after a
  // reset-abandoned access.
  initial begin
    reqT cur;
    bit  active;
    bit  unstable;
    int  cyc;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    active    = 1'b0;
    unstable  = 1'b0;
    cyc       = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!active && mem_req) begin
        if (reqQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("[TB] FAIL unexpected_mem_req: addr %h we %b, required no request", mem_addr, mem_we);
          cur.we    = mem_we;
          cur.addr  = mem_addr;
          cur.wdata = mem_wdata;
          cur.lat   = 1;
        end else begin
          cur = reqQ.pop_front();
          checkOutput("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
          checkOutput("mem_addr", mem_addr, cur.addr);
          checkOutput("mem_wdata", mem_wdata, cur.wdata);
        end
        active   = 1'b1;
        cyc      = 0;
        unstable = 1'b0;
      end
      if (active) begin
        if (mem_req) begin
          cyc++;
          if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wdata !== cur.wdata) unstable = 1'b1;
          if (cur.lat > 0 && cyc == cur.lat) begin
            mem_ack = 1'b1;
            if (cur.we) begin
              bankMem[cur.addr] = cur.wdata;
              mem_rdata = $urandom;
            end else begin
              mem_rdata = bankMem.exists(cur.addr) ? bankMem[cur.addr] : initWord(cur.addr);
            end
          end
        end else begin
          checkOutput("req_stable", {31'b0, unstable}, 32'd0);
          if (cur.lat >= 0) begin
            checkOutput("req_cycles", 32'(cyc), 32'(cur.lat > 0 ? cur.lat : TIMEOUT));
          end else begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5A5A_A5A5;
          end
          active = 1'b0;
        end
      end
    end
  end

  // Retire monitor: a retire is the first non-stalled cycle after stalling.
  initial begin
    respT e;
    int   run;
    bit   prev;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        run  = 0;
      end else if (stall) begin
        run++;
        prev = 1'b1;
      end else begin
        if (prev) begin
          if (respQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL unexpected_retire: read_data %h, required no retire", read_data);
          end else begin
            e = respQ.pop_front();
            checkOutput("load_valid", {31'b0, load_valid}, {31'b0, e.lv});
            checkOutput("bus_err", {31'b0, bus_err}, {31'b0, e.be});
            checkOutput("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            checkOutput("read_data", read_data, e.rd);
            checkOutput("stall_cycles", 32'(run), 32'(e.stallCycles));
          end
        end else if (load_valid || bus_err || misaligned) begin
          nTests++;
          nFail++;
          $display("[TB] FAIL spurious_pulse: lv %b be %b mis %b, required 0", load_valid, bus_err, misaligned);
        end
        prev = 1'b0;
        run  = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", nFail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        opRd;
    logic        opWr;
    logic [31:0] a;
    int          sel;
    int          lat;
    rst        = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    addr       = 32'h0;
    store_data = 32'h0;
    modelRd    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_read_data", read_data, 32'd0);
    checkOutput("reset_load_valid", {31'b0, load_valid}, 32'd0);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("reset_misaligned", {31'b0, misaligned}, 32'd0);
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    idleCycles(1);

    bankMem[32'h10] = 32'h1234_5678;
    refMem[32'h10]  = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 2);
    idleCycles(1);

    applyStimulus(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1);
    idleCycles(1);

    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 0);
    idleCycles(1);

    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 3);
    idleCycles(2);

    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 1);
    idleCycles(1);

    resetMidTransaction();
    idleCycles(1);

    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 9);
      opRd = (sel < 5) || (sel == 9);
      opWr = (sel >= 5);
      a    = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      lat  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
      applyStimulus(opRd, opWr, a, $urandom, lat);
      if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(0, 2));
    end
    idleCycles(4);

    checkOutput("req_queue_drained", 32'(reqQ.size()), 32'd0);
    checkOutput("resp_queue_drained", 32'(respQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
